// File: rtl/twos_comp_decoder.sv
// Serial two's-complement to sign/magnitude decoder: one bit per clock, LSB first,
// with valid/ready handshakes on both sides.
module twos_comp_decoder #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             busy
);

    localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              sign_q, sign_d;
    logic              seen_one_q, seen_one_d;
    logic              bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            mag_q      <= '0;
            idx_q      <= '0;
            sign_q     <= 1'b0;
            seen_one_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            mag_q      <= mag_d;
            idx_q      <= idx_d;
            sign_q     <= sign_d;
            seen_one_q <= seen_one_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mag_d      = mag_q;
        idx_d      = idx_q;
        sign_d     = sign_q;
        seen_one_d = seen_one_q;
        bit_in     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    sign_d     = in_data[WIDTH-1];
                    idx_d      = '0;
                    seen_one_d = 1'b0;
                    mag_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                bit_in = data_q[idx_q];
                // Negation serially: copy bits up to and including the first 1, invert the rest.
                if (sign_q) begin
                    mag_d[idx_q] = bit_in ^ seen_one_q;
                    seen_one_d   = seen_one_q | bit_in;
                end else begin
                    mag_d[idx_q] = bit_in;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == CONV);
        out_valid = (state_q == DONE);
        out_sign  = sign_q;
        out_mag   = mag_q;
    end

endmodule

// File: doc/twos_comp_decoder.md
TWOS_COMP_DECODER -- requirements
Module: twos_comp_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the data word width in bits; legal range 2..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, producer offers in_data.
REQ-005 SHALL have port in_ready, output, 1, block can accept a word.
REQ-006 SHALL have port in_data, input, WIDTH, signed two's-complement word.
REQ-007 SHALL have port out_valid, output, 1, out_sign/out_mag hold a finished result.
REQ-008 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-009 SHALL have port out_sign, output, 1, sign of the decoded word (1 = negative).
REQ-010 SHALL have port out_mag, output, WIDTH, unsigned magnitude.
REQ-011 SHALL have port busy, output, 1, high while a conversion is in progress.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CONV and DONE.
REQ-013 In IDLE: in_ready=1, busy=0, out_valid=0.
REQ-014 In IDLE, on an edge with in_valid=1, SHALL latch in_data and capture sign = in_data[WIDTH-1].
REQ-015 On that same edge, SHALL clear bit index and seen_one, clear out_mag, and go to CONV.
REQ-016 In CONV: in_ready=0, busy=1, out_valid=0; in_valid is ignored.
REQ-017 CONV SHALL process exactly one bit per clock, LSB first (index i = 0..WIDTH-1).
REQ-018 Bit rule for sign=0: out_mag[i] = data[i].
REQ-019 Bit rule for sign=1: out_mag[i] = data[i] XOR seen_one, then seen_one |= data[i]; this is equivalent to ~data + 1.
REQ-020 Latency: the edge that processes i = WIDTH-1 SHALL move to DONE; out_valid is high exactly WIDTH edges after the accept edge, for every input value.
REQ-021 In DONE: out_valid=1, busy=0, in_ready=0.
REQ-022 In DONE, out_sign and out_mag SHALL stay stable until the handshake edge.
REQ-023 In DONE, an edge with out_ready=1 completes the transfer and returns to IDLE.
REQ-024 With out_ready=0 in DONE, the FSM SHALL hold indefinitely (backpressure).
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 Minimum period between accepts is WIDTH+2 cycles (accept, WIDTH CONV edges, handshake edge, then IDLE).
REQ-027 Most-negative input 1 followed by WIDTH-1 zeros SHALL give out_sign=1 and out_mag = same bit pattern (2^(WIDTH-1) unsigned); no overflow flag.
REQ-028 Zero input SHALL give out_sign=0 and out_mag=0.
REQ-029 out_sign SHALL reflect the captured sign from the accept edge until the handshake.
REQ-030 The bit index counter SHALL be wide enough to hold WIDTH-1 without wrapping.
REQ-031 The bit index counter SHALL never exceed WIDTH-1.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, regardless of the current state or clock.
REQ-033 Reset values: in_ready=1, out_valid=0, busy=0, out_sign=0, out_mag=0, bit index=0, seen_one=0, latched data=0.
REQ-034 Reset during CONV or DONE SHALL discard the word in progress; no partial result is ever presented.
REQ-035 The first accept SHALL occur on the first rising edge after rst_n deasserts with in_valid=1.

Verification
REQ-036 WIDTH=5, in_data=00000 -> after 5 edges, out_valid=1, out_sign=0, out_mag=00000.
REQ-037 in_data=00111 -> out_sign=0, out_mag=00111; in_data=11111 -> out_sign=1, out_mag=00001.
REQ-038 in_data=10000 -> out_sign=1, out_mag=10000; in_data=11001 -> out_sign=1, out_mag=00111.
REQ-039 Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1 with outputs unchanged; pulse out_ready -> IDLE next edge, in_ready=1.
REQ-040 Drive in_valid=1 with a new word during CONV -> word ignored, in_ready=0, result matches the first word only.
REQ-041 Assert rst_n=0 at CONV bit 2 -> outputs reset at once, no out_valid pulse; next word decodes correctly.
